// File: rtl/bayer_capture_pkg.sv
// Shared ISP definitions for the Bayer capture front end and the demosaic stage:
// capture FSM state type and the default pixel/counter widths.
package bayer_capture_pkg;

    localparam int ISP_DATA_W   = 12;
    localparam int ISP_CNT_W    = 11;
    localparam int ISP_LINE_LEN = 1280;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        ACTIVE   = 2'd2,
        STOPPING = 2'd3
    } cap_state_e;

    // Pixels are forwarded in both the running and the stop-pending states.
    function automatic logic is_capturing(input cap_state_e s);
        return (s == ACTIVE) || (s == STOPPING);
    endfunction

endpackage

// File: rtl/bayer_capture_xy_counter.sv
// Column/row position counters for the capture stage. The column wraps at
// LINE_LEN and clears at line end; the row advances once per completed line
// segment (wrap or line end with a non-zero column) and saturates.
module bayer_capture_xy_counter
    import bayer_capture_pkg::*;
#(
    parameter int CNT_W    = ISP_CNT_W,
    parameter int LINE_LEN = ISP_LINE_LEN
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             frame_start_i,
    input  logic             pix_valid_i,
    input  logic             line_end_i,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o
);

    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] ROW_MAX  = {CNT_W{1'b1}};

    // col_q/row_q hold the position of the next pixel to arrive
    logic [CNT_W-1:0] col_q, col_d;
    logic [CNT_W-1:0] row_q, row_d;
    logic [CNT_W-1:0] row_inc;
    logic [CNT_W-1:0] x_q, y_q;

    assign row_inc = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;

    // Next position: frame start clears, pixels advance, line end closes a partial line
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (frame_start_i) begin
            col_d = '0;
            row_d = '0;
        end else if (pix_valid_i) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_inc;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (line_end_i && (col_q != '0)) begin
            col_d = '0;
            row_d = row_inc;
        end
    end

    // Position registers plus the output copy aligned with the output pixel
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            col_q <= '0;
            row_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            x_q   <= col_q;
            y_q   <= row_q;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

// File: rtl/bayer_capture.sv
// Raw Bayer capture front end: registers the sensor bus, gates capture with
// start/stop commands and emits pixels with aligned column/row positions.
// Optional feature macro: CAPTURE_FRAME_COUNT_EN (32-bit frame counter on
// oFrame_Cont; tied to zero when undefined).
module bayer_capture
    import bayer_capture_pkg::*;
#(
    parameter int DATA_W   = ISP_DATA_W,
    parameter int CNT_W    = ISP_CNT_W,
    parameter int LINE_LEN = ISP_LINE_LEN
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iFVAL,
    input  logic              iLVAL,
    input  logic              iSTART,
    input  logic              iEND,
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic [CNT_W-1:0]  oX_Cont,
    output logic [CNT_W-1:0]  oY_Cont,
    output logic [31:0]       oFrame_Cont
);

    logic [DATA_W-1:0] rdata_q;
    logic              rfval_q, rlval_q;
    logic              rfval_dly_q, rlval_dly_q;
    logic [DATA_W-1:0] odata_q;
    logic              odval_q;
    cap_state_e        state_q, state_d;

    logic fval_rise, fval_fall, lval_fall;
    logic frame_start, pix_valid;

    assign fval_rise   = rfval_q && !rfval_dly_q;
    assign fval_fall   = !rfval_q && rfval_dly_q;
    assign lval_fall   = !rlval_q && rlval_dly_q;
    assign frame_start = (state_q == ARMED) && (state_d == ACTIVE);
    assign pix_valid   = is_capturing(state_q) && rfval_q && rlval_q;

    // Input registers and one-cycle-delayed strobes for edge detection
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            rdata_q     <= '0;
            rfval_q     <= 1'b0;
            rlval_q     <= 1'b0;
            rfval_dly_q <= 1'b0;
            rlval_dly_q <= 1'b0;
        end else begin
            rdata_q     <= iDATA;
            rfval_q     <= iFVAL;
            rlval_q     <= iLVAL;
            rfval_dly_q <= rfval_q;
            rlval_dly_q <= rlval_q;
        end
    end

    // Capture state register
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command handling; iEND always beats a simultaneous iSTART
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (iSTART && !iEND) state_d = ARMED;
            end
            ARMED: begin
                if (iEND)           state_d = IDLE;
                else if (fval_rise) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (fval_fall)      state_d = iEND ? IDLE : ARMED;
                else if (iEND)      state_d = STOPPING;
            end
            STOPPING: begin
                if (iSTART && !iEND) state_d = fval_fall ? ARMED : ACTIVE;
                else if (fval_fall)  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output pixel stage; data flows every cycle, valid only while capturing
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            odata_q <= '0;
            odval_q <= 1'b0;
        end else begin
            odata_q <= rdata_q;
            odval_q <= pix_valid;
        end
    end

    bayer_capture_xy_counter #(
        .CNT_W    (CNT_W),
        .LINE_LEN (LINE_LEN)
    ) u_xy (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .frame_start_i (frame_start),
        .pix_valid_i   (pix_valid),
        .line_end_i    (lval_fall),
        .x_o           (oX_Cont),
        .y_o           (oY_Cont)
    );

`ifdef CAPTURE_FRAME_COUNT_EN
    logic [31:0] frame_cnt_q;

    // Count every frame that actually starts capture
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            frame_cnt_q <= '0;
        end else if (frame_start) begin
            frame_cnt_q <= frame_cnt_q + 32'd1;
        end
    end

    assign oFrame_Cont = frame_cnt_q;
`else
    assign oFrame_Cont = '0;
`endif

    assign oDATA = odata_q;
    assign oDVAL = odval_q;

endmodule

// File: tb/tb_bayer_capture.sv
// Bench for bayer_capture: two instances (full line length and an 8-pixel
// line) share one stimulus stream and are compared every cycle against a
// per-frame position model, plus a vector table and corner-case sequences.
module tb_bayer_capture;

`ifdef CAPTURE_FRAME_COUNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] din = '0;
    logic        fval = 1'b0, lval = 1'b0, st = 1'b0, en = 1'b0;

    logic [11:0] a_data, b_data;
    logic        a_dval, b_dval;
    logic [10:0] a_x, a_y, b_x, b_y;
    logic [31:0] a_fr, b_fr;

    always #5 clk = ~clk;

    bayer_capture #(.DATA_W(12), .CNT_W(11), .LINE_LEN(1280)) dut_a (
        .iCLK(clk), .iRST(rst_n), .iDATA(din), .iFVAL(fval), .iLVAL(lval),
        .iSTART(st), .iEND(en), .oDATA(a_data), .oDVAL(a_dval),
        .oX_Cont(a_x), .oY_Cont(a_y), .oFrame_Cont(a_fr)
    );

    bayer_capture #(.DATA_W(12), .CNT_W(11), .LINE_LEN(8)) dut_b (
        .iCLK(clk), .iRST(rst_n), .iDATA(din), .iFVAL(fval), .iLVAL(lval),
        .iSTART(st), .iEND(en), .oDATA(b_data), .oDVAL(b_dval),
        .oX_Cont(b_x), .oY_Cont(b_y), .oFrame_Cont(b_fr)
    );

    int vectors = 0;
    int miscompares = 0;
    bit mon_on = 1'b0;
    int dv_a = 0, dv_b = 0;
    int ys_a[$];
    int ys_b[$];

    task automatic chk(input string tag,
                       input logic adv, input logic [11:0] ad, input int ax, input int ay, input logic [31:0] af,
                       input logic edv, input logic [11:0] ed, input int ex, input int ey, input logic [31:0] ef);
        bit bad;
        vectors++;
        bad = (adv !== edv) || (ad !== ed) || (af !== ef) || (edv && ((ax != ex) || (ay != ey)));
        if (bad) begin
            miscompares++;
            $display("FAIL %s @%0t: got dval=%0b data=%h x=%0d y=%0d frame=%0d, expected dval=%0b data=%h x=%0d y=%0d frame=%0d",
                     tag, $time, adv, ad, ax, ay, af, edv, ed, ex, ey, ef);
        end
    endtask

    task automatic chk_int(input string tag, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Position rule: within a line the n-th captured pixel sits at column
    // n mod len and row base + n div len; a finished line of n pixels adds
    // ceil(n/len) rows to the base. Capture enable follows the command rules.
    logic [11:0] m_d[2];
    logic        m_f[2], m_fp[2], m_l[2], m_lp[2];
    int          mode[2];      // 0 stopped, 1 waiting for frame, 2 capturing
    bit          stopq[2];     // stop requested while capturing
    int          npix[2], rbase[2], frames[2];
    logic        e_dv[2];
    logic [11:0] e_d[2];
    int          e_x[2], e_y[2];

    function automatic int llen(input int m);
        return (m == 0) ? 1280 : 8;
    endfunction

    function automatic logic [31:0] fexp(input int m);
        return (FC_ON != 0) ? 32'(frames[m]) : 32'd0;
    endfunction

    task automatic m_reset();
        for (int m = 0; m < 2; m++) begin
            m_d[m] = '0; m_f[m] = 0; m_fp[m] = 0; m_l[m] = 0; m_lp[m] = 0;
            mode[m] = 0; stopq[m] = 0; npix[m] = 0; rbase[m] = 0; frames[m] = 0;
            e_dv[m] = 0; e_d[m] = '0; e_x[m] = 0; e_y[m] = 0;
        end
    endtask

    task automatic m_step(input int m);
        bit cap, rise, fall, lfall, valid;
        int len, y;
        len   = llen(m);
        cap   = (mode[m] == 2);
        rise  = m_f[m] && !m_fp[m];
        fall  = !m_f[m] && m_fp[m];
        lfall = !m_l[m] && m_lp[m];
        valid = cap && m_f[m] && m_l[m];
        e_d[m]  = m_d[m];
        e_dv[m] = valid;
        if (valid) begin
            e_x[m] = npix[m] % len;
            y = rbase[m] + npix[m] / len;
            e_y[m] = (y > 2047) ? 2047 : y;
            npix[m]++;
        end
        if (lfall) begin
            rbase[m] += (npix[m] + len - 1) / len;
            npix[m] = 0;
        end
        case (mode[m])
            0: if (st && !en) mode[m] = 1;
            1: begin
                if (en) mode[m] = 0;
                else if (rise) begin
                    mode[m] = 2; frames[m]++; npix[m] = 0; rbase[m] = 0;
                end
            end
            default: begin
                if (!stopq[m]) begin
                    if (fall) mode[m] = en ? 0 : 1;
                    else if (en) stopq[m] = 1;
                end else begin
                    if (st && !en) begin
                        stopq[m] = 0;
                        if (fall) mode[m] = 1;
                    end else if (fall) begin
                        mode[m] = 0; stopq[m] = 0;
                    end
                end
            end
        endcase
        m_fp[m] = m_f[m]; m_lp[m] = m_l[m];
        m_f[m] = fval; m_l[m] = lval; m_d[m] = din;
    endtask

    always @(posedge clk) if (rst_n) begin m_step(0); m_step(1); end
    always @(negedge rst_n) m_reset();

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) if (mon_on) begin
        chk("cycle A", a_dval, a_data, int'(a_x), int'(a_y), a_fr, e_dv[0], e_d[0], e_x[0], e_y[0], fexp(0));
        chk("cycle B", b_dval, b_data, int'(b_x), int'(b_y), b_fr, e_dv[1], e_d[1], e_x[1], e_y[1], fexp(1));
        if (a_dval) dv_a++;
        if (b_dval) dv_b++;
        if (a_dval && a_x == 11'd0) ys_a.push_back(int'(a_y));
        if (b_dval && b_x == 11'd0) ys_b.push_back(int'(b_y));
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_stats();
        dv_a = 0; dv_b = 0;
        ys_a.delete(); ys_b.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        st = 0; en = 0; fval = 0; lval = 0; din = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
    endtask

    task automatic pulse(input bit s, input bit e);
        st = s; en = e;
        tick();
        st = 0; en = 0;
    endtask

    task automatic send_frame(input int lines, input int pix, input int st_ln, input int en_ln);
        fval = 1; tick(); tick();
        for (int l = 0; l < lines; l++) begin
            lval = 1;
            for (int p = 0; p < pix; p++) begin
                din = 12'($urandom);
                st = (l == st_ln) && (p == 1);
                en = (l == en_ln) && (p == 1);
                tick();
            end
            st = 0; en = 0; lval = 0; din = '0;
            tick(); tick();
        end
        fval = 0;
        repeat (3) tick();
    endtask

    typedef struct {
        logic        fval, lval, start, stop;
        logic [11:0] data;
        logic        e_dval;
        logic [11:0] e_data;
        int          e_x, e_y, e_frame;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_reset();
        // fval lval start stop data | dval data x y frame
        tbl[0]  = '{0, 0, 1, 0, 12'h000, 0, 12'h000, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 1};
        tbl[3]  = '{1, 1, 0, 0, 12'h123, 0, 12'h000, 0, 0, 1};
        tbl[4]  = '{1, 1, 0, 0, 12'h456, 1, 12'h123, 0, 0, 1};
        tbl[5]  = '{1, 1, 0, 0, 12'h789, 1, 12'h456, 1, 0, 1};
        tbl[6]  = '{1, 0, 0, 0, 12'h000, 1, 12'h789, 2, 0, 1};
        tbl[7]  = '{1, 1, 0, 0, 12'hABC, 0, 12'h000, 0, 0, 1};
        tbl[8]  = '{1, 0, 0, 0, 12'h000, 1, 12'hABC, 0, 1, 1};
        tbl[9]  = '{0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 1};
        tbl[10] = '{0, 0, 0, 0, 12'h000, 0, 12'h000, 0, 0, 1};

        repeat (3) @(negedge clk);
        chk("reset A", a_dval, a_data, int'(a_x), int'(a_y), a_fr, 1'b0, 12'h0, 0, 0, 32'd0);
        chk("reset B", b_dval, b_data, int'(b_x), int'(b_y), b_fr, 1'b0, 12'h0, 0, 0, 32'd0);
        chk_int("reset X A", int'(a_x), 0);
        chk_int("reset Y A", int'(a_y), 0);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Table: first frame latency and positions after start
        for (int i = 0; i < 11; i++) begin
            fval = tbl[i].fval; lval = tbl[i].lval; st = tbl[i].start; en = tbl[i].stop; din = tbl[i].data;
            @(negedge clk);
            chk($sformatf("table[%0d] A", i), a_dval, a_data, int'(a_x), int'(a_y), a_fr,
                tbl[i].e_dval, tbl[i].e_data, tbl[i].e_x, tbl[i].e_y, 32'(FC_ON * tbl[i].e_frame));
            chk($sformatf("table[%0d] B", i), b_dval, b_data, int'(b_x), int'(b_y), b_fr,
                tbl[i].e_dval, tbl[i].e_data, tbl[i].e_x, tbl[i].e_y, 32'(FC_ON * tbl[i].e_frame));
        end
        st = 0; en = 0; fval = 0; lval = 0; din = '0;

        // One 4x8 frame: 32 valid pixels, rows start at 0..3
        do_reset();
        pulse(1, 0);
        send_frame(4, 8, -1, -1);
        chk_int("4x8 dval count", dv_a, 32);
        chk_int("4x8 line starts", ys_a.size(), 4);
        for (int i = 0; i < ys_a.size(); i++) chk_int($sformatf("4x8 line %0d Y", i), ys_a[i], i);
        chk_int("4x8 frame count", int'(a_fr), FC_ON);

        // Arming mid-frame: that frame is skipped, the next one is captured
        do_reset();
        fval = 1; repeat (3) tick();
        pulse(1, 0);
        for (int l = 0; l < 2; l++) begin
            lval = 1; repeat (6) tick();
            lval = 0; repeat (2) tick();
        end
        fval = 0; repeat (3) tick();
        chk_int("mid-frame arm dval", dv_a, 0);
        send_frame(3, 5, -1, -1);
        chk_int("next frame dval", dv_a, 15);
        chk_int("next frame count", int'(a_fr), FC_ON);

        // Line wrap on the 8-pixel instance: 16,16,4 pixel lines
        do_reset();
        pulse(1, 0);
        fval = 1; tick(); tick();
        for (int l = 0; l < 3; l++) begin
            lval = 1;
            for (int p = 0; p < ((l == 2) ? 4 : 16); p++) begin din = 12'($urandom); tick(); end
            lval = 0; tick(); tick();
        end
        fval = 0; repeat (3) tick();
        chk_int("wrap dval B", dv_b, 36);
        chk_int("wrap line starts B", ys_b.size(), 5);
        for (int i = 0; i < ys_b.size(); i++) chk_int($sformatf("wrap start %0d Y B", i), ys_b[i], i);
        chk_int("wrap line starts A", ys_a.size(), 3);

        // Stop during line 2: frame completes, the following frame is ignored
        do_reset();
        pulse(1, 0);
        send_frame(4, 8, -1, 1);
        chk_int("stop frame dval", dv_a, 32);
        send_frame(2, 5, -1, -1);
        chk_int("after stop dval", dv_a, 32);
        chk_int("after stop frame count", int'(a_fr), FC_ON);

        // Start and end together while armed: stop wins
        do_reset();
        pulse(1, 0);
        pulse(1, 1);
        send_frame(2, 4, -1, -1);
        chk_int("start+end dval", dv_a, 0);

        // Asynchronous reset in the middle of a line
        do_reset();
        pulse(1, 0);
        fval = 1; tick(); tick();
        lval = 1;
        begin
            bit found;
            found = 0;
            for (int c = 0; c < 40 && !found; c++) begin
                din = 12'($urandom);
                @(negedge clk);
                if (a_dval && a_x == 11'd5) found = 1;
            end
            chk_int("reached X=5", int'(found), 1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk("async reset A", a_dval, a_data, int'(a_x), int'(a_y), a_fr, 1'b0, 12'h0, 0, 0, 32'd0);
        chk("async reset B", b_dval, b_data, int'(b_x), int'(b_y), b_fr, 1'b0, 12'h0, 0, 0, 32'd0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        clear_stats();
        repeat (3) tick();
        pulse(1, 0);
        repeat (4) tick();
        lval = 0; tick(); tick();
        fval = 0; repeat (3) tick();
        chk_int("post-reset same frame dval", dv_a, 0);
        send_frame(2, 4, -1, -1);
        chk_int("post-reset new frame dval", dv_a, 8);

        // Randomized frames and commands against the model
        do_reset();
        pulse(1, 0);
        for (int f = 0; f < 25; f++) begin
            int lines, pix, sl, el;
            if ($urandom_range(2) == 0) pulse(1, 0);
            if ($urandom_range(4) == 0) pulse(0, 1);
            lines = 1 + $urandom_range(3);
            pix   = 2 + $urandom_range(18);
            sl = ($urandom_range(3) == 0) ? $urandom_range(lines - 1) : -1;
            el = ($urandom_range(3) == 0) ? $urandom_range(lines - 1) : -1;
            send_frame(lines, pix, sl, el);
            repeat ($urandom_range(3)) tick();
        end

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
